// File: rtl/ip_codma_bus_arbiter_if.sv
// ip_codma_bus_arbiter_if: requester-side and memory-port signals of the CODMA bus arbiter
// master: the arbiter (drives grants, memory request and error report)
// slave : the environment (requesters plus memory port)
interface ip_codma_bus_arbiter_if #(parameter int NUM_REQ = 3);
    logic [NUM_REQ-1:0]      req_i;
    logic [NUM_REQ-1:0][3:0] size_i;
    logic [NUM_REQ-1:0]      write_i;
    logic                    abort_i;
    logic [NUM_REQ-1:0]      gnt_o;
    logic                    mem_req_o;
    logic [3:0]              mem_size_o;
    logic                    mem_write_o;
    logic                    mem_grant_i;
    logic                    mem_rvalid_i;
    logic                    mem_wready_i;
    logic                    mem_error_i;
    logic                    err_o;
    logic [1:0]              err_code_o;
    logic [1:0]              owner_o;
    modport master (
        input  req_i, size_i, write_i, abort_i, mem_grant_i, mem_rvalid_i, mem_wready_i, mem_error_i,
        output gnt_o, mem_req_o, mem_size_o, mem_write_o, err_o, err_code_o, owner_o
    );
    modport slave (
        output req_i, size_i, write_i, abort_i, mem_grant_i, mem_rvalid_i, mem_wready_i, mem_error_i,
        input  gnt_o, mem_req_o, mem_size_o, mem_write_o, err_o, err_code_o, owner_o
    );
endinterface

// File: rtl/ip_codma_bus_arbiter.sv
// ip_codma_bus_arbiter: round-robin owner of the CODMA memory port with burst beat counting and watchdog
// clk_i   : clock, rising edge
// reset_i : asynchronous active-high reset
// bus     : requesters (req/size/write/abort, gnt) and memory port (req/size/write, grant/rvalid/wready/error), err/err_code/owner
module ip_codma_bus_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    ip_codma_bus_arbiter_if.master  bus
);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_BUSY, ARB_ERR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rr_ptr, rr_d, owner_d, code_d, win, idx, bm1_q, bm1_d;
    logic [2:0]    beat_cnt, beat_d;
    logic [WW-1:0] wd_cnt, wd_d;
    logic [3:0]    size_q, size_d, sz;
    logic          wr_q, wr_d, active, beat, last, done, wd_exp, sz_ok;

    function automatic logic [1:0] nxt(input logic [1:0] o);
        return o == 2'(NUM_REQ - 1) ? 2'd0 : o + 2'd1;
    endfunction

    // Scan downward so the requester closest at/after rr_ptr is the last to overwrite win.
    always_comb begin
        win = rr_ptr;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = 2'((int'(rr_ptr) + i) % NUM_REQ);
            win = bus.req_i[idx] ? idx : win;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_ptr;
        owner_d = bus.owner_o;
        code_d  = bus.err_code_o;
        size_d  = size_q;
        wr_d    = wr_q;
        bm1_d   = bm1_q;
        beat_d  = beat_cnt;
        sz      = bus.size_i[win];
        sz_ok   = sz == 4'd3 || sz == 4'd8 || sz == 4'd9;
        active  = state_q == ARB_REQ || state_q == ARB_BUSY;
        wd_d    = active && wd_cnt != '1 ? wd_cnt + 1'b1 : wd_cnt;
        beat    = wr_q ? bus.mem_wready_i : bus.mem_rvalid_i;
        last    = beat && beat_cnt == {1'b0, bm1_q};
        // a beat coincident with the memory grant already counts
        done    = last && (state_q == ARB_BUSY || (state_q == ARB_REQ && bus.mem_grant_i));
        wd_exp  = TIMEOUT != 0 && active && wd_cnt == WW'(TIMEOUT - 1);
        if (bus.abort_i) begin
            state_d = ARB_IDLE;
            rr_d    = active ? nxt(bus.owner_o) : rr_ptr;
        end else if (active && bus.mem_error_i) begin
            state_d = ARB_ERR;
            code_d  = 2'd2;
            rr_d    = nxt(bus.owner_o);
        end else if (wd_exp && !done) begin
            state_d = ARB_ERR;
            code_d  = 2'd3;
            rr_d    = nxt(bus.owner_o);
        end else if (done) begin
            state_d = ARB_IDLE;
            rr_d    = nxt(bus.owner_o);
        end else begin
            case (state_q)
                ARB_IDLE: if (|bus.req_i) begin
                    owner_d = win;
                    size_d  = sz;
                    wr_d    = bus.write_i[win];
                    bm1_d   = sz == 4'd3 ? 2'd0 : sz == 4'd8 ? 2'd2 : 2'd3;
                    beat_d  = '0;
                    wd_d    = '0;
                    state_d = sz_ok ? ARB_REQ : ARB_ERR;
                    code_d  = sz_ok ? code_d : 2'd1;
                    rr_d    = sz_ok ? rr_ptr : nxt(win);
                end
                ARB_REQ: if (bus.mem_grant_i) begin
                    state_d = ARB_BUSY;
                    beat_d  = {2'b0, beat};
                end
                ARB_BUSY: beat_d = beat_cnt + {2'b0, beat};
                default:  state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= ARB_IDLE;
            rr_ptr          <= '0;
            beat_cnt        <= '0;
            wd_cnt          <= '0;
            size_q          <= '0;
            wr_q            <= 1'b0;
            bm1_q           <= '0;
            bus.gnt_o       <= '0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_size_o  <= '0;
            bus.mem_write_o <= 1'b0;
            bus.err_o       <= 1'b0;
            bus.err_code_o  <= '0;
            bus.owner_o     <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr          <= rr_d;
            beat_cnt        <= beat_d;
            wd_cnt          <= wd_d;
            size_q          <= size_d;
            wr_q            <= wr_d;
            bm1_q           <= bm1_d;
            bus.gnt_o       <= state_d == ARB_BUSY ? NUM_REQ'(1) << owner_d : '0;
            bus.mem_req_o   <= state_d == ARB_REQ || state_d == ARB_BUSY;
            bus.mem_size_o  <= state_d == ARB_REQ || state_d == ARB_BUSY ? size_d : 4'd0;
            bus.mem_write_o <= (state_d == ARB_REQ || state_d == ARB_BUSY) && wr_d;
            bus.err_o       <= state_d == ARB_ERR;
            bus.err_code_o  <= code_d;
            bus.owner_o     <= owner_d;
        end
    end
endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
// tb_ip_codma_bus_arbiter: scoreboard bench for the CODMA bus arbiter
module tb_ip_codma_bus_arbiter;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    ip_codma_bus_arbiter_if #(.NUM_REQ(3)) bus();
    ip_codma_bus_arbiter #(.NUM_REQ(3), .TIMEOUT(8)) dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));

    // kind 0: burst start (owner, size, write); 1: grant release (gnt vector, cycles held); 2: error (code, owner, request cycles before it)
    typedef struct {int kind; int a; int b; int c;} exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    logic [2:0] pg = '0;
    logic pr = 1'b0;
    int gd = 0;
    int run = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int a, input int b, input int c);
        exp_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        e = '{default: 0};
        ok = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual_kind=%0d expected=none", kind);
        end else begin
            e = exp_q.pop_front();
            ok = e.kind == kind;
            if (!ok) begin
                failures++;
                $display("FAIL event_kind actual=%0d expected=%0d", kind, e.kind);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        bit ok;
        if (reset_i) begin
            pg = '0;
            pr = 1'b0;
            gd = 0;
            run = 0;
        end else begin
            if (pg != 3'b0 && bus.gnt_o == 3'b0) begin
                pop_exp(1, e, ok);
                if (ok) begin
                    check("gnt_vector", int'(pg), e.a);
                    check("gnt_cycles", gd, e.b);
                    check("mem_req_at_release", int'(bus.mem_req_o), 0);
                end
            end
            if (bus.mem_req_o && !pr) begin
                pop_exp(0, e, ok);
                if (ok) begin
                    check("start_owner", int'(bus.owner_o), e.a);
                    check("start_mem_size", int'(bus.mem_size_o), e.b);
                    check("start_mem_write", int'(bus.mem_write_o), e.c);
                end
            end
            if (bus.err_o) begin
                pop_exp(2, e, ok);
                if (ok) begin
                    check("err_code", int'(bus.err_code_o), e.a);
                    check("err_owner", int'(bus.owner_o), e.b);
                    check("req_cycles_before_err", run, e.c);
                end
            end
            gd = bus.gnt_o != 3'b0 ? gd + 1 : 0;
            pg = bus.gnt_o;
            pr = bus.mem_req_o;
            run = bus.mem_req_o ? run + 1 : 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        bus.req_i = '0;
        bus.size_i = '0;
        bus.write_i = '0;
        bus.abort_i = 1'b0;
        bus.mem_grant_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_wready_i = 1'b0;
        bus.mem_error_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        check("reset_gnt", int'(bus.gnt_o), 0);
        check("reset_mem_req", int'(bus.mem_req_o), 0);
        check("reset_mem_size", int'(bus.mem_size_o), 0);
        check("reset_mem_write", int'(bus.mem_write_o), 0);
        check("reset_err", int'(bus.err_o), 0);
        check("reset_err_code", int'(bus.err_code_o), 0);
        check("reset_owner", int'(bus.owner_o), 0);
        tick();

        // round robin: three single-beat reads, order 0,1,2,0
        bus.req_i = 3'b111;
        bus.size_i = {4'd3, 4'd3, 4'd3};
        bus.write_i = 3'b000;
        for (int i = 0; i < 4; i++) begin
            push(0, i % 3, 3, 0);
            push(1, 1 << (i % 3), 1, 0);
            tick();
            bus.mem_grant_i = 1'b1;
            tick();
            bus.mem_grant_i = 1'b0;
            bus.mem_rvalid_i = 1'b1;
            if (i == 3) bus.req_i = 3'b000;
            tick();
            bus.mem_rvalid_i = 1'b0;
        end
        repeat (2) tick();

        // single size-9 read by requester 1, grant after one wait, one gap before the beats
        push(0, 1, 9, 0);
        push(1, 2, 5, 0);
        bus.req_i = 3'b010;
        bus.size_i = {4'd3, 4'd9, 4'd3};
        tick();
        bus.req_i = 3'b000;
        tick();
        bus.mem_grant_i = 1'b1;
        tick();
        bus.mem_grant_i = 1'b0;
        tick();
        bus.mem_rvalid_i = 1'b1;
        repeat (4) tick();
        bus.mem_rvalid_i = 1'b0;
        repeat (2) tick();

        // all request, pointer at 2 picks the size-8 writer; rvalid held high must be ignored
        push(0, 2, 8, 1);
        push(1, 4, 5, 0);
        bus.req_i = 3'b111;
        bus.size_i = {4'd8, 4'd3, 4'd3};
        bus.write_i = 3'b100;
        tick();
        bus.req_i = 3'b000;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_grant_i = 1'b1;
        tick();
        bus.mem_grant_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_wready_i = (i % 2) == 0;
            tick();
        end
        bus.mem_wready_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.write_i = 3'b000;
        repeat (2) tick();

        // bad size code 5 from requester 0
        push(2, 1, 0, 0);
        bus.req_i = 3'b001;
        bus.size_i = {4'd3, 4'd3, 4'd5};
        tick();
        bus.req_i = 3'b000;
        repeat (3) tick();

        // bus error on the second beat of a size-9 read, then requester 2 is served
        push(0, 1, 9, 0);
        push(1, 2, 2, 0);
        push(2, 2, 1, 3);
        push(0, 2, 3, 0);
        push(1, 4, 1, 0);
        bus.req_i = 3'b110;
        bus.size_i = {4'd3, 4'd9, 4'd3};
        tick();
        bus.req_i = 3'b100;
        bus.mem_grant_i = 1'b1;
        tick();
        bus.mem_grant_i = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        tick();
        bus.mem_error_i = 1'b1;
        tick();
        bus.mem_error_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        repeat (2) tick();
        bus.req_i = 3'b000;
        bus.mem_grant_i = 1'b1;
        tick();
        bus.mem_grant_i = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        tick();
        bus.mem_rvalid_i = 1'b0;
        repeat (2) tick();

        // abort during a burst, coincident with a bus error: abort wins, no error pulse
        push(0, 0, 9, 0);
        push(1, 1, 2, 0);
        bus.req_i = 3'b001;
        bus.size_i = {4'd3, 4'd3, 4'd9};
        tick();
        bus.req_i = 3'b000;
        bus.mem_grant_i = 1'b1;
        tick();
        bus.mem_grant_i = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        tick();
        bus.mem_rvalid_i = 1'b0;
        bus.abort_i = 1'b1;
        bus.mem_error_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.mem_error_i = 1'b0;
        repeat (2) tick();
        check("err_code_held_after_abort", int'(bus.err_code_o), 2);

        // watchdog: grant never arrives, eight request cycles then timeout
        push(0, 1, 3, 0);
        push(2, 3, 1, 8);
        bus.req_i = 3'b010;
        bus.size_i = {4'd3, 4'd3, 4'd3};
        tick();
        bus.req_i = 3'b000;
        repeat (12) tick();
        check("err_code_held_after_timeout", int'(bus.err_code_o), 3);

        // asynchronous reset in the middle of a granted burst
        push(0, 0, 9, 0);
        bus.req_i = 3'b001;
        bus.size_i = {4'd3, 4'd3, 4'd9};
        tick();
        bus.req_i = 3'b000;
        bus.mem_grant_i = 1'b1;
        tick();
        bus.mem_grant_i = 1'b0;
        #1;
        check("gnt_before_async_reset", int'(bus.gnt_o), 1);
        reset_i = 1'b1;
        #1;
        check("gnt_async_reset", int'(bus.gnt_o), 0);
        check("mem_req_async_reset", int'(bus.mem_req_o), 0);
        repeat (2) tick();
        reset_i = 1'b0;
        check("err_code_after_reset", int'(bus.err_code_o), 0);
        check("owner_after_reset", int'(bus.owner_o), 0);
        repeat (3) tick();

        check("pending_expectations", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
